// File: rtl/combat_resolver.sv
// Combat resolver: arms on attack_req, resolves hit/block/whiff
// on the next tick, then cools down; health 0 latches KO.
// Ports: clk, rst (async, active-low), tick, attack_req,
//   atk_type, def_type, x_diff -> health, hit, blocked,
//   busy (ARMED/COOLDOWN), ko (KO state).
module combat_resolver #(
  parameter int             HW         = 4,
  parameter int             MAX_HEALTH = 8,
  parameter int             XW         = 10,
  parameter int             RANGE      = 175,
  parameter int             COOLDOWN   = 50_000_000,
  parameter int             CDW        = 32,
  parameter logic [HW-1:0]  DMG0       = HW'(1),
  parameter logic [HW-1:0]  DMG1       = HW'(1),
  parameter logic [HW-1:0]  DMG2       = HW'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          attack_req,
  input  logic [1:0]    atk_type,
  input  logic [1:0]    def_type,
  input  logic [XW-1:0] x_diff,
  output logic [HW-1:0] health,
  output logic          hit,
  output logic          blocked,
  output logic          busy,
  output logic          ko
);

  localparam logic [HW-1:0]  HMAX    = HW'(MAX_HEALTH);
  localparam logic [CDW-1:0] CD_LAST = CDW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_COOL,
    S_KO
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [HW-1:0]  r_health;
  logic [HW-1:0]  w_health_nxt;
  logic [CDW-1:0] r_cnt;
  logic [CDW-1:0] w_cnt_nxt;
  logic           r_hit;
  logic           w_hit_nxt;
  logic           r_blk;
  logic           w_blk_nxt;

  logic           w_in_range;
  logic           w_rule;
  logic           w_hits;
  logic [HW-1:0]  w_dmg;
  logic [HW-1:0]  w_health_dmg;
  logic [HW-1:0]  w_health_after;

  assign w_in_range = 32'(x_diff) < 32'(RANGE);

  always_comb begin
    w_rule = 1'b0;
    w_dmg  = '0;
    unique case (atk_type)
      2'b00: begin
        w_rule = (def_type == 2'b00);
        w_dmg  = DMG0;
      end
      2'b01: begin
        w_rule = (def_type != 2'b10);
        w_dmg  = DMG1;
      end
      2'b10: begin
        w_rule = (def_type == 2'b01);
        w_dmg  = DMG2;
      end
      2'b11: begin
        w_rule = 1'b0;
        w_dmg  = '0;
      end
    endcase
  end

  assign w_hits = w_in_range && w_rule;

  // Saturate at zero: damage at or above health means KO.
  assign w_health_dmg = (w_dmg >= r_health) ? '0
                      : r_health - w_dmg;

  assign w_health_after = w_hits ? w_health_dmg : r_health;

  always_comb begin
    w_state_nxt  = r_state;
    w_health_nxt = r_health;
    w_cnt_nxt    = r_cnt;
    w_hit_nxt    = 1'b0;
    w_blk_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (attack_req) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (tick) begin
          w_cnt_nxt    = '0;
          w_health_nxt = w_health_after;
          w_hit_nxt    = w_hits;
          w_blk_nxt    = w_in_range && !w_hits
                      && (atk_type != 2'b11);
          w_state_nxt  = (w_health_after == '0) ? S_KO
                       : S_COOL;
        end
      end
      S_COOL: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CD_LAST) w_state_nxt = S_IDLE;
      end
      S_KO: begin
        w_state_nxt = S_KO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_health <= HMAX;
      r_cnt    <= '0;
      r_hit    <= 1'b0;
      r_blk    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_health <= w_health_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hit    <= w_hit_nxt;
      r_blk    <= w_blk_nxt;
    end
  end

  assign health  = r_health;
  assign hit     = r_hit;
  assign blocked = r_blk;
  assign busy    = (r_state == S_ARMED)
                || (r_state == S_COOL);
  assign ko      = (r_state == S_KO);

endmodule
